fir_decim_fifo: RTL and testbench
=================================

Name: fir_decim_fifo

Overview:
- Sits directly downstream of the 9-tap FIR and consumes its 16-bit signed filtered sample stream.
- Discards the FIR's start-up transient after reset, then decimates by DECIM.
- Buffers the kept samples in a small synchronous FIFO.
- Presents them on a valid/ready interface to the slower back-end, with sticky overflow reporting.

Parameters:
- DATA_W, 16: sample width (signed).
- DECIM, 4: decimation ratio; keep 1 of every DECIM accepted samples; legal range ≥1.
- WARMUP, 14: number of accepted samples discarded after reset; legal range ≥0.
- DEPTH, 8: FIFO depth in entries; must be a power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock, shared with FIR.
- rst  in  1  synchronous, active-high reset.
- in_sample  in  DATA_W  signed FIR output sample.
- in_valid  in  1  sample strobe; tie high when the FIR produces a sample every clk.
- out_data  out  DATA_W  head-of-FIFO sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle when out_valid=1.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset is synchronous, active-high, and may be asserted at any cycle, including mid-operation. On rst=1 at a clk edge:
  - state=WARM, warm_cnt=0, phase=0
  - FIFO rd/wr pointers=0, level=0, out_valid=0, out_data=0, overflow=0
  - FIFO contents are discarded. Memory array is not reset.
- Accepted sample: in_valid=1 at a clk edge with rst=0. Cycles with in_valid=0 change no counter.
- State WARM:
  - Each accepted sample increments warm_cnt and is discarded.
  - When the WARMUP-th sample is accepted, go to RUN with phase=0.
  - WARMUP=0 means the block leaves reset directly in RUN.
- State RUN:
  - Each accepted sample is kept iff phase==0.
  - phase increments per accepted sample and wraps DECIM-1→0.
  - DECIM=1 keeps every sample.
  - RUN persists until reset.
- Push: a kept sample is written at the same edge.
  - Full and no pop this cycle: the sample is dropped and overflow is set.
  - Full with a simultaneous pop: the write succeeds and level stays DEPTH.
- Pop: out_valid & out_ready at an edge advances rd_ptr. out_ready while empty is ignored.
- Show-ahead output:
  - out_data = mem[rd_ptr] when level>0, else 0.
  - out_valid = (level>0).
- Latency: a sample kept at edge t into an empty FIFO is visible with out_valid=1 from just after edge t, i.e. in cycle t+1. There is no same-cycle bypass.
- Simultaneous push and pop at level L (0<L≤DEPTH): level stays L, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is a separate counter. The data path is a pure copy: no arithmetic, no width change.
- overflow:
  - Set on any drop.
  - Cleared by clr_ovf=1 when no drop occurs in that cycle.
  - Set wins over clear in the same cycle.
- out_ready is permitted to toggle freely. out_data must stay stable while out_valid=1 and no pop occurs.

Decomposition:
- Shared package fir_pkg holds:
  - SAMPLE_W=16
  - typedef sample_t (signed SAMPLE_W)
  - FIR_TAPS=9
  - FIR_LAT=6 (FIR input-to-output register stages)
  - WARMUP_DEFAULT = FIR_LAT+FIR_TAPS-1 = 14
- One sub-module: sample_fifo, a synchronous show-ahead FIFO.
  - Parameterised by width and depth.
  - Ports: wr_en, wr_data, rd_en, rd_data, level, full, empty.
- fir_decim_fifo holds the WARM/RUN FSM, warm_cnt, phase counter and overflow logic.

Test Plan:
- Warm-up discard:
  - Stimulus: rst 2 cycles, then in_valid=1 with in_sample = 1, 2, 3, … and out_ready=1.
  - Required: first out_data=15 (WARMUP=14), then 19, 23, 27, …; out_valid never asserts before the edge that keeps 15.
- Decimation with gaps:
  - Stimulus: DECIM=4, in_valid pattern 1,0,1,1,0,1,…
  - Required: only every 4th accepted sample is output; idle cycles do not advance phase.
- Full/overflow:
  - Stimulus: DECIM=1, WARMUP=0, out_ready=0, push 10 samples 100..109.
  - Required: level reaches 8 at sample 107; samples 108 and 109 dropped; overflow=1.
  - Then out_ready=1 drains 100..107 in order, and level returns to 0.
- Full with simultaneous pop:
  - Stimulus: level=8, out_ready=1, continuous pushes.
  - Required: level stays 8, no drop, overflow stays 0.
  - Clear priority: clr_ovf=1 in the same cycle as a drop leaves overflow=1; clr_ovf on the next cycle clears it.
- Reset mid-operation:
  - Stimulus: rst with level=5, phase=2, overflow=1.
  - Required: next cycle level=0, out_valid=0, out_data=0, overflow=0, and the 14-sample warm-up repeats.
- Backpressure stability:
  - Stimulus: out_ready toggles 1,0,0,1 with the FIFO non-empty.
  - Required: out_data holds while out_ready=0; the sequence is lossless and in order.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output chain: sample format, FIR geometry,
// and the decimator/FIFO sequencing states.
package fir_pkg;

  localparam int SAMPLE_W = 16;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam int FIR_TAPS = 9;
  localparam int FIR_LAT = 6;
  // Samples until the FIR delay line holds only post-reset data.
  localparam int WARMUP_DEFAULT = FIR_LAT + FIR_TAPS - 1;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } dec_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO; the head entry is presented combinationally,
// and a write while full is accepted only if a read frees a slot at the same edge.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign level = count;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fir_decim_fifo.sv
// FIR back-end: drops the start-up transient, decimates by DECIM and buffers
// kept samples for a valid/ready consumer with sticky overflow reporting.
module fir_decim_fifo import fir_pkg::*; #(
  parameter int DATA_W = SAMPLE_W,
  parameter int DECIM  = 4,
  parameter int WARMUP = WARMUP_DEFAULT,
  parameter int DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATA_W-1:0]    in_sample,
  input  logic                        in_valid,
  output logic signed [DATA_W-1:0]    out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  input  logic                        clr_ovf
);

  localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DECIM - 1);
  localparam dec_state_t        RST_STATE = (WARMUP > 0) ? ST_WARM : ST_RUN;

  dec_state_t        state, state_nxt;
  logic [WARM_W-1:0] warm_cnt, warm_nxt;
  logic [PH_W-1:0]   phase, phase_nxt;
  logic              keep;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      warm_cnt <= '0;
      phase    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_nxt;
      phase    <= phase_nxt;
      overflow <= drop | (overflow & ~clr_ovf);
    end
  end

  always_comb begin
    state_nxt = state;
    warm_nxt  = warm_cnt;
    phase_nxt = phase;
    keep      = 1'b0;
    if (in_valid) begin
      case (state)
        ST_WARM: begin
          warm_nxt = warm_cnt + 1'b1;
          if (warm_cnt == WARM_LAST) begin
            state_nxt = ST_RUN;
            phase_nxt = '0;
          end
        end
        default: begin
          keep      = (phase == '0);
          phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
      endcase
    end
  end

  // A kept sample is lost only when the FIFO stays full through this edge.
  assign pop       = out_valid & out_ready;
  assign drop      = keep & fifo_full & ~pop;
  assign out_valid = ~fifo_empty;

  sample_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (keep),
    .wr_data (in_sample),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: a default instance and a DECIM=1/WARMUP=0 instance
// share stimulus and are each tracked by a queue-style behavioural model.
module tb_fir_decim_fifo;
  import fir_pkg::*;

  localparam int DEPTH = 8;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  sample_t in_sample = '0;
  logic    in_valid = 1'b0;
  logic    out_ready = 1'b0;
  logic    clr_ovf = 1'b0;

  sample_t    d_data  [2];
  logic       d_valid [2];
  logic [3:0] d_level [2];
  logic       d_ovf   [2];

  always #5 clk = ~clk;

  fir_decim_fifo u_dut0 (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
    .out_data(d_data[0]), .out_valid(d_valid[0]), .out_ready(out_ready),
    .level(d_level[0]), .overflow(d_ovf[0]), .clr_ovf(clr_ovf)
  );

  fir_decim_fifo #(.DECIM(1), .WARMUP(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
    .out_data(d_data[1]), .out_valid(d_valid[1]), .out_ready(out_ready),
    .level(d_level[1]), .overflow(d_ovf[1]), .clr_ovf(clr_ovf)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: count of accepted samples since reset plus a list of buffered values.
  int m_warm [2] = '{14, 0};
  int m_dec  [2] = '{4, 1};
  int m_n    [2];
  int m_head [2];
  int m_tail [2];
  int m_buf  [2][64];
  bit m_ovf  [2];

  int pops0[$];
  int acc[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int  size;
    bit  pop, keep;
    size = m_tail[k] - m_head[k];
    if (rst) begin
      m_n[k] = 0; m_head[k] = 0; m_tail[k] = 0; m_ovf[k] = 1'b0;
    end else begin
      pop = (size > 0) && out_ready;
      keep = 1'b0;
      if (in_valid) begin
        keep = (m_n[k] >= m_warm[k]) && ((m_n[k] - m_warm[k]) % m_dec[k] == 0);
        m_n[k]++;
      end
      if (pop) begin m_head[k]++; size--; end
      if (keep && size >= DEPTH) m_ovf[k] = 1'b1;
      else begin
        if (keep) begin m_buf[k][m_tail[k] % 64] = int'(in_sample); m_tail[k]++; end
        if (clr_ovf) m_ovf[k] = 1'b0;
      end
    end
  endtask

  task automatic model_cmp(input int k);
    int size;
    size = m_tail[k] - m_head[k];
    chk($sformatf("m%0d.valid", k), int'(d_valid[k]), int'(size > 0));
    chk($sformatf("m%0d.level", k), int'(d_level[k]), size);
    chk($sformatf("m%0d.data", k), int'(d_data[k]), (size > 0) ? m_buf[k][m_head[k] % 64] : 0);
    chk($sformatf("m%0d.ovf", k), int'(d_ovf[k]), int'(m_ovf[k]));
  endtask

  task automatic tick();
    if (d_valid[0] && out_ready && !rst) pops0.push_back(int'(d_data[0]));
    if (in_valid && !rst) acc.push_back(int'(in_sample));
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    model_cmp(0);
    model_cmp(1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
    pops0.delete();
    acc.delete();
  endtask

  typedef struct {
    logic iv; int s; logic rdy; logic clr;
    int lvl; logic vld; int dat; logic ovf;
  } vec_t;
  vec_t tbl[32];

  initial begin
    // Overflow / drain / full-with-pop vectors for the DECIM=1, WARMUP=0 instance.
    for (int i = 0; i < 10; i++)
      tbl[i] = '{1'b1, 100 + i, 1'b0, (i == 9), (i < 8) ? i + 1 : 8, 1'b1, 100, (i >= 8)};
    tbl[10] = '{1'b0, 0, 1'b0, 1'b1, 8, 1'b1, 100, 1'b0};
    for (int j = 0; j < 8; j++)
      tbl[11 + j] = '{1'b0, 0, 1'b1, 1'b0, 7 - j, (j < 7), (j < 7) ? 101 + j : 0, 1'b0};
    for (int j = 0; j < 8; j++)
      tbl[19 + j] = '{1'b1, 200 + j, 1'b0, 1'b0, j + 1, 1'b1, 200, 1'b0};
    for (int j = 0; j < 4; j++)
      tbl[27 + j] = '{1'b1, 208 + j, 1'b1, 1'b0, 8, 1'b1, 201 + j, 1'b0};
    tbl[31] = '{1'b1, 212, 1'b0, 1'b0, 8, 1'b1, 204, 1'b1};

    // Reset state
    do_reset(2);
    chk("rst.level0", int'(d_level[0]), 0);
    chk("rst.valid0", int'(d_valid[0]), 0);
    chk("rst.data0", int'(d_data[0]), 0);
    chk("rst.ovf1", int'(d_ovf[1]), 0);

    // Warm-up discard with a ramp
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_sample = sample_t'(i + 1);
      tick();
      if (i == 13) chk("warm.no_valid_at_14", int'(d_valid[0]), 0);
      if (i == 14) begin
        chk("warm.valid_at_15", int'(d_valid[0]), 1);
        chk("warm.first_data", int'(d_data[0]), 15);
      end
    end
    in_valid = 1'b0;
    chk("warm.pop_count", pops0.size() >= 4 ? 1 : 0, 1);
    for (int k = 0; k < 4 && k < pops0.size(); k++)
      chk($sformatf("warm.pop%0d", k), pops0[k], 15 + 4 * k);

    // Table-driven vectors for the full/overflow corner cases
    do_reset(2);
    for (int i = 0; i < 32; i++) begin
      in_valid = tbl[i].iv; in_sample = sample_t'(tbl[i].s);
      out_ready = tbl[i].rdy; clr_ovf = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d.level", i), int'(d_level[1]), tbl[i].lvl);
      chk($sformatf("tbl%0d.valid", i), int'(d_valid[1]), int'(tbl[i].vld));
      chk($sformatf("tbl%0d.data", i), int'(d_data[1]), tbl[i].dat);
      chk($sformatf("tbl%0d.ovf", i), int'(d_ovf[1]), int'(tbl[i].ovf));
    end
    clr_ovf = 1'b0;

    // Decimation with idle gaps (pattern 1,0,1,1,0,1)
    do_reset(2);
    out_ready = 1'b1;
    for (int c = 0; c < 150; c++) begin
      in_valid = (c % 6 != 1) && (c % 6 != 4);
      in_sample = sample_t'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("decim.pop_count", pops0.size(), (acc.size() - 14 + 3) / 4);
    for (int k = 0; k < pops0.size(); k++)
      if (14 + 4 * k < acc.size()) chk($sformatf("decim.pop%0d", k), pops0[k], acc[14 + 4 * k]);

    // Reset mid-operation: reach level=5, phase=2, overflow=1, then reset
    do_reset(2);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_sample = sample_t'(500 + i);
      tick();
    end
    chk("mid.ovf_set", int'(d_ovf[0]), 1);
    chk("mid.full", int'(d_level[0]), 8);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b1; out_ready = 1'b0;
    tick(); tick();
    chk("mid.level5", int'(d_level[0]), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid.rst_level", int'(d_level[0]), 0);
    chk("mid.rst_valid", int'(d_valid[0]), 0);
    chk("mid.rst_data", int'(d_data[0]), 0);
    chk("mid.rst_ovf", int'(d_ovf[0]), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_sample = sample_t'(1000 + i);
      tick();
      if (i < 14) chk($sformatf("mid.warm%0d", i), int'(d_valid[0]), 0);
    end
    chk("mid.rewarm_valid", int'(d_valid[0]), 1);
    chk("mid.rewarm_data", int'(d_data[0]), 1014);

    // Backpressure pattern 1,0,0,1 then fully random traffic
    do_reset(2);
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom % 4) != 0;
      in_sample = sample_t'($urandom);
      out_ready = (c < 300) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'($urandom % 2);
      clr_ovf = ($urandom % 16) == 0;
      rst = (c > 300) && (($urandom % 200) == 0);
      tick();
    end
    rst = 1'b0; clr_ovf = 1'b0; in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
